// File: rtl/uart_pkg.sv
// Shared UART receive constants and the small helpers used by the sampling front end.
package uart_pkg;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   DEF_SYNC_STAGES = 2;
    localparam int   MIN_PRESCALE    = 8;

    // Mid-bit edge index; odd ratios round down.
    function automatic logic [31:0] mid_edge(input logic [31:0] prescale);
        return prescale >> 1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchroniser; every flop resets to RST_VAL so the output
// comes out of reset at the line's idle level.
module bit_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/data_sampling.sv
// UART RX oversampling front end: synchronises RX_IN, takes three samples just
// before mid-bit and registers their majority vote plus a noise indication.
module data_sampling
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int EDGE_W       = 6,
    parameter int MIN_PRESCALE = uart_pkg::MIN_PRESCALE
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic              dat_samp_en,
    input  logic [EDGE_W-1:0] prescale,
    input  logic [EDGE_W-1:0] edge_cnt,
    output logic              rx_sync,
    output logic              sampled_bit,
    output logic              sample_valid,
    output logic              noise_flag
);

    localparam logic [EDGE_W-1:0] MIN_P = EDGE_W'(MIN_PRESCALE);

    logic [EDGE_W-1:0] mid;
    logic [EDGE_W-1:0] idx0;
    logic [EDGE_W-1:0] idx1;
    logic [EDGE_W-1:0] idx2;
    logic              active;
    logic              cap0;
    logic              cap1;
    logic              cap2;
    logic [2:0]        s;

    bit_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (UART_IDLE_LEVEL)
    ) u_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (RX_IN),
        .q     (rx_sync)
    );

    // Below MIN_P the index arithmetic would underflow, so sampling is simply gated off.
    assign mid    = EDGE_W'(mid_edge(32'(prescale)));
    assign idx0   = mid - EDGE_W'(4);
    assign idx1   = mid - EDGE_W'(3);
    assign idx2   = mid - EDGE_W'(2);
    assign active = dat_samp_en && (prescale >= MIN_P);
    assign cap0   = active && (edge_cnt == idx0);
    assign cap1   = active && (edge_cnt == idx1);
    assign cap2   = active && (edge_cnt == idx2);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s <= {3{UART_IDLE_LEVEL}};
        end else if (!dat_samp_en) begin
            s <= {3{UART_IDLE_LEVEL}};
        end else begin
            if (cap0) s[0] <= rx_sync;
            if (cap1) s[1] <= rx_sync;
            if (cap2) s[2] <= rx_sync;
        end
    end

    // The third sample is taken straight from rx_sync so the result lands one edge before mid-bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sampled_bit  <= UART_IDLE_LEVEL;
            sample_valid <= 1'b0;
            noise_flag   <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (cap2) begin
                sampled_bit  <= maj3(s[0], s[1], rx_sync);
                noise_flag   <= !((s[0] == s[1]) && (s[1] == rx_sync));
                sample_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/data_sampling.md
Name: data_sampling

Overview:
UART RX oversampling front end. It synchronises the asynchronous serial line into the CLK domain and takes three samples per bit, just before mid-bit, at positions set by the externally supplied edge counter. It majority-votes the three samples into `sampled_bit`. It sits directly upstream of the start-check, parity-check, stop-check and deserializer stages and feeds `sampled_bit` to all of them. The vote completes before the mid-bit edge count at which the downstream checkers read it.

Parameters:
- SYNC_STAGES, 2, number of flops in the RX_IN synchroniser (minimum 2).
- EDGE_W, 6, width of `prescale` and `edge_cnt`.
- MIN_PRESCALE, 8, smallest oversampling ratio for which sampling is active.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; asynchronous, active-low.
- RX_IN  in  1  raw serial line, asynchronous; idle level is 1.
- dat_samp_en  in  1  sampling enable from the RX FSM.
- prescale  in  EDGE_W  oversampling ratio (8/16/32 nominal); static while `dat_samp_en`=1.
- edge_cnt  in  EDGE_W  current edge position within the bit, 0..prescale-1, from the edge/bit counter.
- rx_sync  out  1  synchronised RX_IN, used by the FSM for idle/start detection.
- sampled_bit  out  1  registered majority-vote result.
- sample_valid  out  1  one-cycle pulse on the cycle `sampled_bit` updates.
- noise_flag  out  1  set when the three samples of the current bit were not unanimous.

Behaviour:
- Reset (RST=0, asynchronous): all synchroniser flops=1, rx_sync=1, sample register s[2:0]=3'b111, sampled_bit=1, sample_valid=0, noise_flag=0.
- Synchroniser: RX_IN passes through SYNC_STAGES flops. rx_sync = last stage. Latency from RX_IN to rx_sync = SYNC_STAGES cycles. The synchroniser runs regardless of `dat_samp_en`.
- Sample points: define M = prescale >> 1 (floor for odd values). Three sample indices are used: M-4, M-3 and M-2. For prescale=16 these are 4, 5, 6.
- On each clock with dat_samp_en=1, prescale>=MIN_PRESCALE, and edge_cnt equal to a sample index, capture rx_sync into s[0], s[1] or s[2] respectively.
- Vote: on the clock where edge_cnt == M-2, compute the result from s[0], s[1] and the current rx_sync (the third sample):
  - sampled_bit <= majority(s[0], s[1], rx_sync).
  - noise_flag <= 1 if the three are not all equal, else 0.
  - sample_valid <= 1.
- Result timing: `sampled_bit` is therefore stable from the cycle edge_cnt == M-1 (7 for prescale=16) until the next vote. This is the cycle at which the start, parity and stop checkers read it.
- `sample_valid` is high for exactly one cycle per bit, in the cycle edge_cnt == M-1, and is 0 otherwise.
- `dat_samp_en` = 0:
  - s is forced to 3'b111 and sample_valid = 0.
  - sampled_bit and noise_flag hold their last values.
  - If `dat_samp_en` deasserts mid-bit, any partial sample set is discarded.
- prescale < MIN_PRESCALE: no captures occur and no votes are taken. sample_valid stays 0 and sampled_bit holds. The synchroniser keeps running.
- edge_cnt skipping a sample index (counter restart or prescale change): the stale s value is used in the vote. No error is generated. The FSM is responsible for consistent sequencing.
- Simultaneous events: capture and vote for the same index cannot collide because the indices are distinct. Asynchronous reset overrides everything.
- `noise_flag` is informational only. It does not alter `sampled_bit`.

Decomposition:
- Shared package uart_pkg:
  - UART_IDLE_LEVEL = 1'b1.
  - DEF_SYNC_STAGES = 2.
  - MIN_PRESCALE = 8.
  - Function `mid_edge(prescale)` returning prescale>>1.
  - Function `maj3(a, b, c)`.
- One sub-module: bit_sync, an N-stage synchroniser with reset value parameterised (reset to UART_IDLE_LEVEL here).

Test Plan:
- Reset release with RX_IN=1 idle -> rx_sync=1, sampled_bit=1, sample_valid=0, noise_flag=0. After 2 cycles of RX_IN=0, rx_sync=0.
- prescale=16, dat_samp_en=1, rx_sync held 0 across a full bit, edge_cnt sweeping 0..15 -> sample_valid pulse at edge_cnt=7, sampled_bit=0, noise_flag=0.
- prescale=16, rx_sync=0 at edges 4 and 6 and 1 at edge 5 -> sampled_bit=0, noise_flag=1. Repeat with 1,1,0 at edges 4,5,6 -> sampled_bit=1, noise_flag=1.
- prescale=8 and prescale=32 -> votes taken at edges 2 and 14 respectively, sample_valid pulses at edges 3 and 15, correct majority for patterns 000, 011 and 111.
- dat_samp_en dropped after edge 5, then re-enabled at the next bit with data 0,0,0 -> no pulse in the aborted bit, next bit gives sampled_bit=0.
- prescale=4 with enable high -> sample_valid never asserts and sampled_bit holds. Asynchronous RST pulse mid-bit -> all outputs return to reset values immediately, without waiting for a CLK edge.
